uart_tx_fifo: RTL

Parametrised, buffered UART transmitter that replaces the fixed 8N1 transmitter in the serial TX path. Words enter through a valid/ready handshake into an internal FIFO and are serialised LSB-first. Data width, stop bits and baud divisor are configurable by parameter; parity mode is configurable at run time. Frames drain back-to-back, so upstream logic can queue bursts instead of polling a transmit-enable flag.

---
 rtl/uart_tx_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a circular FIFO,
// drained back-to-back as start/data/parity/stop frames, LSB first.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 10416,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_BITS-1:0]                 wr_data,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [1:0]                           parity_mode,
  output logic                                 tx,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] headWord;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parityBit_q, parityBit_d;
  logic                 parityEn_q, parityEn_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bitEnd;
  logic                 startFrame;
  logic                 headParity;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign wr_ready   = !rst && (level_q != LVL_FULL);
  assign push       = wr_valid && wr_ready;
  assign headWord   = mem_q[rdPtr_q];
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= wr_data;
  end

  always_comb begin
    headParity = 1'b0;
    case (parity_mode)
      2'b01:   headParity = ^headWord;
      2'b10:   headParity = ~(^headWord);
      2'b11:   headParity = 1'b1;
      default: headParity = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = (baud_q == BAUD_LAST) ? '0 : baud_q + BAUD_W'(1);
    bitCnt_d    = bitCnt_q;
    stopCnt_d   = stopCnt_q;
    shift_d     = shift_q;
    parityBit_d = parityBit_q;
    parityEn_d  = parityEn_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    startFrame  = 1'b0;
    bitEnd      = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (level_q != '0) startFrame = 1'b1;
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt_q == BIT_LAST) begin
            if (parityEn_q) begin
              state_d = PARITY;
              tx_d    = parityBit_q;
            end else begin
              state_d   = STOP;
              tx_d      = 1'b1;
              stopCnt_d = 1'b0;
            end
          end else begin
            bitCnt_d = bitCnt_q + BIT_W'(1);
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          stopCnt_d = 1'b0;
        end
      end
      STOP: begin
        // Registered pulse, so it is armed one clock early to land on the last stop clock.
        if (baud_q == BAUD_PENULT && stopCnt_q == STOP_LAST) done_d = 1'b1;
        if (bitEnd) begin
          if (stopCnt_q == STOP_LAST) begin
            if (level_q != '0) begin
              startFrame = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (startFrame) begin
      pop         = 1'b1;
      state_d     = START;
      tx_d        = 1'b0;
      baud_d      = '0;
      shift_d     = headWord;
      parityEn_d  = (parity_mode != 2'b00);
      parityBit_d = headParity;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      baud_q      <= '0;
      bitCnt_q    <= '0;
      stopCnt_q   <= 1'b0;
      shift_q     <= '0;
      parityBit_q <= 1'b0;
      parityEn_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bitCnt_q    <= bitCnt_d;
      stopCnt_q   <= stopCnt_d;
      shift_q     <= shift_d;
      parityBit_q <= parityBit_d;
      parityEn_q  <= parityEn_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule
